pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-field inter-stage registers (ID/EXE and similar).
- Carries an opaque payload bus plus a control bus through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so there is no combinational ready path between stages.
- Synchronous flush kills in-flight entries: it clears valid and control bits (write enables, branch, jal, and so on) so a squashed instruction can have no side effects.

---
 rtl/pipe_stage_reg.sv | 190 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised inter-stage pipeline register with a valid/ready handshake.
// It replaces the older fixed-field stage registers (ID/EXE and similar).
// A two-entry skid buffer keeps full throughput while in_ready stays a
// registered signal, so ready never forms a combinational path across stages.
//
// Entries:
//   M (main) : drives the outputs directly.
//   S (skid) : catches the one entry accepted while M is stalled.
//   Invariant: S valid implies M valid. Ordering is strictly M before S.
//
// Flush kills every held entry. It clears the valid and control bits so that a
// squashed instruction cannot have side effects. Payload bits are left alone.
// If the entry in M is emitted in the same cycle, that transfer still counts
// downstream. An accept in the same cycle is discarded.
//
// Optional feature (macro PIPE_STAGE_PERF_EN):
//   Adds the stall_cnt and bubble_cnt outputs (32-bit, wrapping). They are
//   cleared only by rst, and flush has no effect on them.
//
// Parameters:
//   DATA_W   payload width (pc, immediate, operands, ...)
//   CTRL_W   control width (reg_wen, mem_wen, branch, ...)
//   RST_DATA payload value loaded on rst
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high; overrides flush and transfers
//   flush      synchronous kill of all held entries
//   in_valid   upstream entry valid
//   in_ready   stage can accept (registered, = !S.valid)
//   in_data    upstream payload
//   in_ctrl    upstream control
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_data   main payload
//   out_ctrl   main control, zero whenever out_valid is low
//   stall_cnt  (PIPE_STAGE_PERF_EN) cycles with out_valid && !out_ready
//   bubble_cnt (PIPE_STAGE_PERF_EN) cycles with out_valid low
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned         DATA_W   = 64,
  parameter int unsigned         CTRL_W   = 12,
  parameter logic [DATA_W-1:0]   RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // Main entry.
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;

  // Skid entry.
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic accept;
  logic emit;

  // in_ready comes straight from a flop, so there is no comb path from out_ready.
  assign in_ready  = ~s_valid_q;
  assign accept    = in_valid & in_ready;
  assign emit      = m_valid_q & out_ready;

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Control bits are loaded only on an accept, which requires in_valid. A
  // bubble therefore can never place nonzero ctrl into an entry, and every
  // path that invalidates an entry also zeroes its ctrl.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;

    if (flush) begin
      // Any same-cycle emit has already happened on the wire. Any same-cycle
      // accept is dropped. Payload is kept so that the data lanes do not toggle.
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (!m_valid_q) begin
      // S must be empty here (invariant), so a new entry always goes to M.
      if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end
    end else if (emit) begin
      if (s_valid_q) begin
        // Drain the skid entry into M. in_ready was low, so no accept this cycle.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
        s_ctrl_d  = '0;
      end else if (accept) begin
        // Streaming case: one entry in and one entry out per cycle.
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (accept) begin
      // M is stalled. Park the new entry in S; in_ready drops next cycle.
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_ctrl_d  = in_ctrl;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= RST_DATA;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= RST_DATA;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (cleared by rst only, wrap modulo 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_valid_q && !out_ready) stall_cnt_d  = stall_cnt_q + 32'd1;
    if (!m_valid_q)              bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 12;
  localparam logic [DATA_W-1:0] RST_DATA = 64'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .RST_DATA(RST_DATA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Advance one rising edge, then settle 1 time unit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [11:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF, 12'hFFF);
    #1;

    // Reset for 2 cycles while a valid entry with full ctrl is presented.
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 64'h0, 12'h000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl",  out_ctrl,  0);
    chk("rst_out_data",  out_data,  RST_DATA);
    chk("rst_in_ready",  in_ready,  1);

    // A bubble leaves the stage empty.
    tick();
    chk("bubble_empty", out_valid, 0);

    // Streaming 1..8 with out_ready high: 1-cycle latency, in_ready stays 1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 12'(i));
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data,  64'(i));
      chk("stream_ctrl",  out_ctrl,  64'(i));
      chk("stream_ready", in_ready,  1);
    end
    drive(1'b0, 64'h55, 12'hFFF);
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_ctrl",  out_ctrl,  0);

    // Backpressure: A enters M, B is caught in S, C is held upstream.
    drive(1'b1, 64'hA, 12'h001);
    tick();
    chk("bp_A_in_M", out_data, 64'hA);
    out_ready = 1'b0;
    drive(1'b1, 64'hB, 12'h002);
    tick();
    chk("bp_hold_A",      out_data, 64'hA);
    chk("bp_ready_low",   in_ready, 0);
    drive(1'b1, 64'hC, 12'h003);
    tick();
    chk("bp_still_A",     out_data, 64'hA);
    chk("bp_ctrl_A",      out_ctrl, 64'h001);
    chk("bp_ready_low2",  in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_B_data",      out_data, 64'hB);
    chk("bp_B_ctrl",      out_ctrl, 64'h002);
    chk("bp_ready_back",  in_ready, 1);
    tick();
    chk("bp_C_data",      out_data, 64'hC);
    chk("bp_C_ctrl",      out_ctrl, 64'h003);
    drive(1'b0, 64'h0, 12'h000);
    tick();
    chk("bp_drained",     out_valid, 0);

    // Flush with M=A (ctrl 0A5) and S=B while D is offered.
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 12'h0A5);
    tick();
    chk("fl_A_ctrl", out_ctrl, 64'h0A5);
    drive(1'b1, 64'hB, 12'h03C);
    tick();
    chk("fl_S_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 64'hD, 12'hFFF);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 12'h000);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl",  out_ctrl,  0);
    chk("fl_in_ready",  in_ready,  1);
    chk("fl_data_kept", out_data,  64'hA);
    out_ready = 1'b1;
    tick();
    chk("fl_no_B_or_D", out_valid, 0);

    // An accept in the same cycle as a flush on an empty stage is discarded.
    drive(1'b1, 64'hE, 12'h0FF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 12'h000);
    chk("fl_accept_drop", out_valid, 0);
    chk("fl_accept_ctrl", out_ctrl,  0);

    // Flush together with an emit: A leaves once and the stage is empty after.
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 12'h0A5);
    tick();
    drive(1'b0, 64'h0, 12'h000);
    out_ready = 1'b1;
    flush = 1'b1;
    chk("fe_emit_valid", out_valid, 1);
    chk("fe_emit_data",  out_data,  64'hA);
    tick();
    flush = 1'b0;
    chk("fe_empty",      out_valid, 0);
    chk("fe_ctrl_zero",  out_ctrl,  0);
    tick();
    chk("fe_no_dup",     out_valid, 0);

    // rst overrides flush and an offered entry, and restores RST_DATA.
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 64'h77, 12'hFFF);
    tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 64'h0, 12'h000);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data",  out_data,  RST_DATA);
    chk("rst2_ready", in_ready,  1);

`ifdef PIPE_STAGE_PERF_EN
    chk("perf_rst_stall",  stall_cnt,  0);
    chk("perf_rst_bubble", bubble_cnt, 0);
    // Three empty cycles.
    tick(); tick(); tick();
    chk("perf_bubble3", bubble_cnt, 3);
    // Loading A: out_valid still low on this edge, so the bubble count reaches 4.
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 12'h001);
    tick();
    drive(1'b0, 64'h0, 12'h000);
    chk("perf_bubble4", bubble_cnt, 4);
    for (int i = 0; i < 5; i++) tick();
    chk("perf_stall5", stall_cnt, 5);
    // Flush with an emit: no stall on this edge.
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_flush_stall",  stall_cnt,  5);
    chk("perf_flush_bubble", bubble_cnt, 4);
    tick(); tick();
    chk("perf_post_flush",   bubble_cnt, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_clr_stall",  stall_cnt,  0);
    chk("perf_clr_bubble", bubble_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
